// File: rtl/sd_data_serial_card.sv
// Card-side SD 4-bit DAT engine: receives write blocks and answers with a CRC-status
// token plus busy, and transmits read blocks with per-line CRC16.
module sd_data_serial_card #(
  parameter int BLK_BYTES = 512,
  parameter int NAC_CYC   = 2,
  parameter int BUSY_CYC  = 8
) (
  input  logic        sd_clk,
  input  logic        rst,
  input  logic [3:0]  DAT_dat_i,
  output logic [3:0]  DAT_dat_o,
  output logic        DAT_oe_o,
  input  logic [1:0]  start_dat,
  output logic [31:0] rx_data,
  output logic        rx_we,
  input  logic [31:0] tx_data,
  output logic        tx_rd,
  output logic        crc_fail,
  output logic        done,
  output logic        busy
);

  localparam int NIB = 2 * BLK_BYTES;
  localparam int CW  = $clog2(NIB + 17);
  localparam logic [CW-1:0] NIB_LAST  = CW'(NIB - 1);
  localparam logic [CW-1:0] NIB_PRE   = CW'(NIB - 2);
  localparam logic [CW-1:0] NAC_LAST  = CW'(NAC_CYC - 1);
  localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_CYC);
  localparam logic [CW-1:0] CRC_LAST  = CW'(15);
  localparam logic [CW-1:0] TOK_LAST  = CW'(4);
  localparam logic [CW-1:0] GAP_LAST  = CW'(1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_RX_WAIT, ST_RX_DAT, ST_RX_CRC, ST_RX_END, ST_TOK_GAP, ST_TOKEN,
    ST_BUSY, ST_TX_NAC, ST_TX_START, ST_TX_DAT, ST_TX_CRC, ST_TX_END
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    word_q;
  logic [3:0][15:0] crc_q;
  logic [3:0][15:0] crc_nxt;
  logic [3:0][15:0] crc_shl;
  logic [3:0]     crc_msb;
  logic [3:0]     crc_in;
  logic           err_q;
  logic [31:0]    rx_data_q;
  logic           rx_we_q, tx_rd_q, crc_fail_q, done_q;
  logic [3:0]     tx_nib;
  logic [2:0]     tok_status;
  logic           tok_bit;
  logic           drv_oe_d;
  logic [3:0]     drv_dat_d;
  logic           oe_q;
  logic [3:0]     dat_q;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    crc16_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign crc_in = (state_q == ST_RX_DAT) ? DAT_dat_i : tx_nib;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_line
      assign crc_nxt[gi] = crc16_step(crc_q[gi], crc_in[gi]);
      assign crc_shl[gi] = {crc_q[gi][14:0], 1'b0};
      assign crc_msb[gi] = crc_q[gi][15];
    end
  endgenerate

  // Big-endian nibble selection from the word being transmitted.
  always_comb begin
    case (cnt_q[2:0])
      3'd0:    tx_nib = word_q[31:28];
      3'd1:    tx_nib = word_q[27:24];
      3'd2:    tx_nib = word_q[23:20];
      3'd3:    tx_nib = word_q[19:16];
      3'd4:    tx_nib = word_q[15:12];
      3'd5:    tx_nib = word_q[11:8];
      3'd6:    tx_nib = word_q[7:4];
      default: tx_nib = word_q[3:0];
    endcase
  end

  assign tok_status = crc_fail_q ? 3'b101 : 3'b010;

  always_comb begin
    case (cnt_q[2:0])
      3'd0:    tok_bit = 1'b0;
      3'd1:    tok_bit = tok_status[2];
      3'd2:    tok_bit = tok_status[1];
      3'd3:    tok_bit = tok_status[0];
      default: tok_bit = 1'b1;
    endcase
  end

  always_comb begin
    drv_oe_d  = 1'b0;
    drv_dat_d = 4'hF;
    case (state_q)
      ST_TOKEN:    begin drv_oe_d = 1'b1; drv_dat_d = {3'b111, tok_bit}; end
      ST_BUSY:     begin drv_oe_d = 1'b1; drv_dat_d = {3'b111, cnt_q == BUSY_LAST}; end
      ST_TX_START: begin drv_oe_d = 1'b1; drv_dat_d = 4'h0; end
      ST_TX_DAT:   begin drv_oe_d = 1'b1; drv_dat_d = tx_nib; end
      ST_TX_CRC:   begin drv_oe_d = 1'b1; drv_dat_d = crc_msb; end
      ST_TX_END:   begin drv_oe_d = 1'b1; drv_dat_d = 4'hF; end
      default:     ;
    endcase
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      crc_q      <= '0;
      err_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_we_q    <= 1'b0;
      tx_rd_q    <= 1'b0;
      crc_fail_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rx_we_q <= 1'b0;
      tx_rd_q <= 1'b0;
      done_q  <= 1'b0;
      // The host buffer advances on the edge that sees tx_rd, so latch its word here.
      if (tx_rd_q) word_q <= tx_data;
      if (state_q != ST_IDLE && start_dat == 2'b11) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            cnt_q <= '0;
            crc_q <= '0;
            err_q <= 1'b0;
            if (start_dat == 2'b01) begin
              state_q    <= ST_RX_WAIT;
              crc_fail_q <= 1'b0;
            end else if (start_dat == 2'b10) begin
              state_q <= ST_TX_NAC;
              if (NAC_LAST == '0) tx_rd_q <= 1'b1;
            end
          end
          ST_RX_WAIT: if (DAT_dat_i == 4'b0000) state_q <= ST_RX_DAT;
          ST_RX_DAT: begin
            word_q <= {word_q[27:0], DAT_dat_i};
            crc_q  <= crc_nxt;
            if (cnt_q[2:0] == 3'd7) begin
              rx_data_q <= {word_q[27:0], DAT_dat_i};
              rx_we_q   <= 1'b1;
            end
            if (cnt_q == NIB_LAST) begin
              state_q <= ST_RX_CRC;
              cnt_q   <= '0;
            end else cnt_q <= cnt_q + 1'b1;
          end
          ST_RX_CRC: begin
            err_q <= err_q | (|(DAT_dat_i ^ crc_msb));
            crc_q <= crc_shl;
            if (cnt_q == CRC_LAST) begin
              state_q <= ST_RX_END;
              cnt_q   <= '0;
            end else cnt_q <= cnt_q + 1'b1;
          end
          ST_RX_END: begin
            crc_fail_q <= err_q | (DAT_dat_i != 4'hF);
            state_q    <= ST_TOK_GAP;
            cnt_q      <= '0;
          end
          ST_TOK_GAP: begin
            if (cnt_q == GAP_LAST) begin
              state_q <= ST_TOKEN;
              cnt_q   <= '0;
            end else cnt_q <= cnt_q + 1'b1;
          end
          ST_TOKEN: begin
            if (cnt_q == TOK_LAST) begin
              state_q <= ST_BUSY;
              cnt_q   <= '0;
            end else cnt_q <= cnt_q + 1'b1;
          end
          ST_BUSY: begin
            if (cnt_q == BUSY_LAST) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end else cnt_q <= cnt_q + 1'b1;
          end
          ST_TX_NAC: begin
            if (cnt_q == NAC_LAST) begin
              state_q <= ST_TX_START;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q + 1'b1 == NAC_LAST) tx_rd_q <= 1'b1;
            end
          end
          ST_TX_START: state_q <= ST_TX_DAT;
          ST_TX_DAT: begin
            crc_q <= crc_nxt;
            // Prefetch strobe lands on nibble 7 of every word but the last.
            if (cnt_q[2:0] == 3'd6 && cnt_q != NIB_PRE) tx_rd_q <= 1'b1;
            if (cnt_q == NIB_LAST) begin
              state_q <= ST_TX_CRC;
              cnt_q   <= '0;
            end else cnt_q <= cnt_q + 1'b1;
          end
          ST_TX_CRC: begin
            crc_q <= crc_shl;
            if (cnt_q == CRC_LAST) begin
              state_q <= ST_TX_END;
              cnt_q   <= '0;
            end else cnt_q <= cnt_q + 1'b1;
          end
          ST_TX_END: begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(negedge sd_clk or posedge rst) begin
    if (rst) begin
      oe_q  <= 1'b0;
      dat_q <= 4'hF;
    end else begin
      oe_q  <= drv_oe_d;
      dat_q <= drv_dat_d;
    end
  end

  assign DAT_oe_o  = oe_q;
  assign DAT_dat_o = dat_q;
  assign rx_data   = rx_data_q;
  assign rx_we     = rx_we_q;
  assign tx_rd     = tx_rd_q;
  assign crc_fail  = crc_fail_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sd_data_serial_card.sv
// Directed bench for sd_data_serial_card: host-side write/read blocks with a scoreboard
// of expected rx words and expected DAT bus samples.
module tb_sd_data_serial_card;

  localparam int BLK_BYTES = 512;
  localparam int NIB       = 2 * BLK_BYTES;
  localparam int NWORDS    = BLK_BYTES / 4;
  localparam int NAC_CYC   = 2;
  localparam int BUSY_CYC  = 8;

  logic        sd_clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  DAT_dat_i = 4'hF;
  logic [3:0]  DAT_dat_o;
  logic        DAT_oe_o;
  logic [1:0]  start_dat = 2'b00;
  logic [31:0] rx_data;
  logic        rx_we;
  logic [31:0] tx_data = 32'h0;
  logic        tx_rd;
  logic        crc_fail;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int rx_unexp = 0;
  int txrd_cnt = 0;
  int done_cnt = 0;
  logic [31:0] rx_exp[$];
  logic [9:0]  bus_exp[$];

  always #5 sd_clk = ~sd_clk;

  sd_data_serial_card #(
    .BLK_BYTES(BLK_BYTES),
    .NAC_CYC  (NAC_CYC),
    .BUSY_CYC (BUSY_CYC)
  ) dut (
    .sd_clk   (sd_clk),
    .rst      (rst),
    .DAT_dat_i(DAT_dat_i),
    .DAT_dat_o(DAT_dat_o),
    .DAT_oe_o (DAT_oe_o),
    .start_dat(start_dat),
    .rx_data  (rx_data),
    .rx_we    (rx_we),
    .tx_data  (tx_data),
    .tx_rd    (tx_rd),
    .crc_fail (crc_fail),
    .done     (done),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] ^ b) r = r ^ 16'h1021;
    return r;
  endfunction

  function automatic logic [31:0] word_of(input int base);
    logic [7:0] b;
    b = base[7:0];
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic push_bus(input logic [4:0] mask, input logic [4:0] val, input int n);
    for (int i = 0; i < n; i++) bus_exp.push_back({mask, val & mask});
  endtask

  task automatic bus_check(input string tag, input int n);
    logic [9:0] e;
    for (int k = 0; k < n; k++) begin
      @(posedge sd_clk);
      #1;
      if (bus_exp.size() > 0) begin
        e = bus_exp.pop_front();
        chk(tag, 32'({DAT_oe_o, DAT_dat_o} & e[9:5]), 32'(e[4:0]));
      end
    end
  endtask

  // Receive-side monitor: every rx_we pops one expected word.
  always @(negedge sd_clk) begin
    if (!rst) begin
      if (rx_we) begin
        rx_cnt++;
        if (rx_exp.size() > 0) chk("rx_data", rx_data, rx_exp.pop_front());
        else rx_unexp++;
      end
      if (tx_rd) txrd_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic write_block(input int base, input bit corrupt, input int pre_cnt, input int nchk);
    logic [15:0] crc [4];
    logic [31:0] w;
    logic [3:0]  nib;
    logic [2:0]  s;
    int r0, d0;
    r0 = rx_cnt;
    d0 = done_cnt;
    for (int l = 0; l < 4; l++) crc[l] = 16'h0000;
    bus_exp.delete();
    @(negedge sd_clk); start_dat = 2'b01;
    @(negedge sd_clk); start_dat = 2'b00; DAT_dat_i = 4'hF;
    #1;
    chk("wr_busy", 32'(busy), 32'(1));
    chk("wr_crc_fail_clear", 32'(crc_fail), 32'(0));
    for (int p = 0; p < pre_cnt; p++) begin
      @(negedge sd_clk); DAT_dat_i = 4'b1110;
    end
    @(negedge sd_clk); DAT_dat_i = 4'b0000;
    for (int wi = 0; wi < NWORDS; wi++) begin
      w = word_of(base + 4 * wi);
      rx_exp.push_back(w);
      for (int n = 0; n < 8; n++) begin
        nib = w[31 - 4 * n -: 4];
        @(negedge sd_clk); DAT_dat_i = nib;
        for (int l = 0; l < 4; l++) crc[l] = crc_step(crc[l], nib[l]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge sd_clk);
      for (int l = 0; l < 4; l++) DAT_dat_i[l] = crc[l][15 - i] ^ (corrupt && l == 2 && i == 10);
    end
    @(negedge sd_clk); DAT_dat_i = 4'hF;
    s = corrupt ? 3'b101 : 3'b010;
    push_bus(5'h10, 5'h0F, 2);
    push_bus(5'h1F, 5'b11110, 1);
    push_bus(5'h1F, {4'b1111, s[2]}, 1);
    push_bus(5'h1F, {4'b1111, s[1]}, 1);
    push_bus(5'h1F, {4'b1111, s[0]}, 1);
    push_bus(5'h1F, 5'b11111, 1);
    push_bus(5'h11, 5'b10000, BUSY_CYC);
    push_bus(5'h11, 5'b10001, 1);
    push_bus(5'h1F, 5'h0F, 1);
    @(posedge sd_clk);
    bus_check("wr_bus", nchk);
    chk("wr_rx_count", 32'(rx_cnt - r0), 32'(NWORDS));
    chk("wr_rx_pending", 32'(rx_exp.size()), 32'(0));
    if (nchk >= 17) begin
      chk("wr_done", 32'(done_cnt - d0), 32'(1));
      chk("wr_crc_fail", 32'(crc_fail), 32'(corrupt));
      chk("wr_idle", 32'(busy), 32'(0));
    end
  endtask

  task automatic read_block(input logic [31:0] word, input int abort_nib);
    logic [15:0] crc [4];
    logic [31:0] w;
    logic [3:0]  nib;
    int t0, d0;
    t0 = txrd_cnt;
    d0 = done_cnt;
    w = word;
    tx_data = word;
    for (int l = 0; l < 4; l++) crc[l] = 16'h0000;
    bus_exp.delete();
    push_bus(5'h10, 5'h0F, NAC_CYC);
    push_bus(5'h1F, 5'b10000, 1);
    for (int n = 0; n < NIB; n++) begin
      nib = w[31 - 4 * (n % 8) -: 4];
      push_bus(5'h1F, {1'b1, nib}, 1);
      for (int l = 0; l < 4; l++) crc[l] = crc_step(crc[l], nib[l]);
    end
    for (int i = 0; i < 16; i++)
      push_bus(5'h1F, {1'b1, crc[3][15 - i], crc[2][15 - i], crc[1][15 - i], crc[0][15 - i]}, 1);
    push_bus(5'h1F, 5'h1F, 1);
    push_bus(5'h1F, 5'h0F, 1);
    @(negedge sd_clk); start_dat = 2'b10;
    @(negedge sd_clk); start_dat = 2'b00;
    if (abort_nib < 0) begin
      bus_check("rd_bus", NAC_CYC + 1 + NIB + 16 + 2);
      chk("rd_txrd_count", 32'(txrd_cnt - t0), 32'(NWORDS));
      chk("rd_done", 32'(done_cnt - d0), 32'(1));
    end else begin
      bus_check("rd_bus", NAC_CYC + 1 + abort_nib);
      chk("rd_busy_mid", 32'(busy), 32'(1));
      @(negedge sd_clk); start_dat = 2'b11;
      @(posedge sd_clk); #1;
      chk("abort_busy", 32'(busy), 32'(0));
      @(negedge sd_clk); start_dat = 2'b00;
      #1;
      chk("abort_oe", 32'(DAT_oe_o), 32'(0));
      bus_exp.delete();
      repeat (40) @(negedge sd_clk);
      #1;
      chk("abort_txrd_count", 32'(txrd_cnt - t0), 32'(1 + (abort_nib + 1) / 8));
      chk("abort_no_done", 32'(done_cnt - d0), 32'(0));
      chk("abort_oe_idle", 32'(DAT_oe_o), 32'(0));
    end
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge sd_clk);
    #1;
    chk("rst_oe", 32'(DAT_oe_o), 32'(0));
    chk("rst_dat", 32'(DAT_dat_o), 32'hF);
    chk("rst_rx_data", rx_data, 32'h0);
    chk("rst_rx_we", 32'(rx_we), 32'(0));
    chk("rst_tx_rd", 32'(tx_rd), 32'(0));
    chk("rst_crc_fail", 32'(crc_fail), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(negedge sd_clk); rst = 1'b0;
    repeat (2) @(negedge sd_clk);

    write_block(0, 1'b0, 3, 17);
    write_block(0, 1'b1, 0, 17);
    read_block(32'hDEADBEEF, -1);
    read_block(32'hDEADBEEF, 300);
    chk("crc_fail_held", 32'(crc_fail), 32'(1));

    d0 = done_cnt;
    write_block(64, 1'b0, 0, 10);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy_oe", 32'(DAT_oe_o), 32'(0));
    chk("rst_busy_dat", 32'(DAT_dat_o), 32'hF);
    chk("rst_busy_busy", 32'(busy), 32'(0));
    bus_exp.delete();
    @(negedge sd_clk); rst = 1'b0;
    chk("rst_busy_no_done", 32'(done_cnt - d0), 32'(0));
    repeat (2) @(negedge sd_clk);

    write_block(32, 1'b0, 0, 17);
    chk("rx_unexpected", 32'(rx_unexp), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
